// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the debounce bank and its per-channel logic.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLDING   = 2'd1,
    REPEATING = 2'd2,
    DONE      = 2'd3
  } hold_state_e;

  // Bits needed to hold any value from 0 up to and including n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounced key: two-flop synchroniser, stability counter, edge pulses,
// and a long-press detector with optional auto-repeat.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 120000,
  parameter int   HOLD_CYCLES   = 6000000,
  parameter int   REPEAT_CYCLES = 1200000,
  parameter logic ACTIVE_LOW    = 1'b1,
  parameter logic RESET_LEVEL   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
  output logic repeat_pulse
);

  localparam int SCW = cnt_w(STABLE_CYCLES);
  localparam int HCW = cnt_w(max_int(HOLD_CYCLES, REPEAT_CYCLES));

  localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_LAST   = HCW'(HOLD_CYCLES - 1);
  // With repeat disabled this value is never compared against.
  localparam logic [HCW-1:0] REPEAT_LAST = HCW'(REPEAT_CYCLES - 1);

  logic           sync1;
  logic           sync2;
  logic [SCW-1:0] cnt;
  logic [HCW-1:0] hcnt;
  hold_state_e    state;
  logic           settle;
  logic           press_evt;
  logic           release_evt;

  // Terminal count reached on a differing input: level flips on this edge.
  always_comb begin
    settle      = (sync2 != level) && (cnt == STABLE_LAST);
    press_evt   = settle && ((sync2 ^ ACTIVE_LOW) == 1'b1);
    release_evt = settle && ((sync2 ^ ACTIVE_LOW) == 1'b0);
  end

  // Two-flop synchroniser; sync2 is the only view of the pin the rest of the channel gets.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Stability counter: any return to the current level throws away the partial count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      level         <= RESET_LEVEL;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (settle) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Long-press FSM: hold pulse after HOLD_CYCLES, then periodic repeats until release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hcnt         <= '0;
      hold_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      hold_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      if (release_evt) begin
        state <= IDLE;
        hcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            hcnt <= '0;
            if (press_evt) begin
              state <= HOLDING;
            end
          end
          HOLDING: begin
            if (hcnt == HOLD_LAST) begin
              hold_pulse <= 1'b1;
              hcnt       <= '0;
              state      <= (REPEAT_CYCLES == 0) ? DONE : REPEATING;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
          REPEATING: begin
            if (hcnt == REPEAT_LAST) begin
              repeat_pulse <= 1'b1;
              hcnt         <= '0;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
          DONE: begin
            hcnt <= '0;
          end
          default: begin
            state <= IDLE;
            hcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced keys between the raw KEY/SW pins and the board top.
// Each bit of ACTIVE_LOW / RESET_LEVEL configures the matching channel.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int              N_CH          = 8,
  parameter int              STABLE_CYCLES = 120000,
  parameter logic [N_CH-1:0] ACTIVE_LOW    = '1,
  parameter logic [N_CH-1:0] RESET_LEVEL   = '1,
  parameter int              HOLD_CYCLES   = 6000000,
  parameter int              REPEAT_CYCLES = 1200000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_in,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_hold,
  output logic [N_CH-1:0] o_repeat
);

  // One self-contained channel per input bit; channels share nothing but clock and reset.
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    debounce_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW[ch]),
      .RESET_LEVEL   (RESET_LEVEL[ch])
    ) u_ch (
      .clk           (i_clk),
      .rst           (i_rst),
      .raw           (i_in[ch]),
      .level         (o_level[ch]),
      .press_pulse   (o_press[ch]),
      .release_pulse (o_release[ch]),
      .hold_pulse    (o_hold[ch]),
      .repeat_pulse  (o_repeat[ch])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: stimulus pushes expected pulse events,
// a negedge monitor pops and compares whenever any pulse output is active.
// Instance a repeats every 8 cycles after hold; instance b has repeat disabled.
module tb_debounce_bank;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] hold;
    logic [3:0] rep;
    logic [3:0] level;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] in_a, in_b;
  logic [3:0] level_a, press_a, release_a, hold_a, repeat_a;
  logic [3:0] level_b, press_b, release_b, hold_b, repeat_b;

  int   cycle  = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];

  debounce_bank #(
    .N_CH(4), .STABLE_CYCLES(4), .ACTIVE_LOW(4'b1111), .RESET_LEVEL(4'b1111),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(8)
  ) dut (
    .i_clk(clk), .i_rst(rst_a), .i_in(in_a), .o_level(level_a), .o_press(press_a),
    .o_release(release_a), .o_hold(hold_a), .o_repeat(repeat_a)
  );

  debounce_bank #(
    .N_CH(4), .STABLE_CYCLES(4), .ACTIVE_LOW(4'b1111), .RESET_LEVEL(4'b1111),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(0)
  ) dut_norep (
    .i_clk(clk), .i_rst(rst_b), .i_in(in_b), .o_level(level_b), .o_press(press_b),
    .o_release(release_b), .o_hold(hold_b), .o_repeat(repeat_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic pushExp(input int inst, input int cyc, input logic [3:0] press,
                         input logic [3:0] rel, input logic [3:0] hold,
                         input logic [3:0] rep, input logic [3:0] level);
    exp_t e;
    e.cyc = cyc; e.press = press; e.rel = rel; e.hold = hold; e.rep = rep; e.level = level;
    if (inst == 0) q_a.push_back(e);
    else           q_b.push_back(e);
  endtask

  task automatic monitorInst(input int inst, input logic [3:0] p, input logic [3:0] r,
                             input logic [3:0] h, input logic [3:0] rp, input logic [3:0] lv);
    exp_t e;
    int   n;
    bit   busy;
    busy = ((p | r | h | rp) != 4'b0000);
    n    = (inst == 0) ? q_a.size() : q_b.size();
    while (n > 0) begin
      if (inst == 0) e = q_a[0];
      else           e = q_b[0];
      if (e.cyc >= cycle) break;
      checks++;
      errors++;
      $display("[TB] FAIL missed_event inst=%0d cycle=%0d: nothing seen, required press=%b rel=%b hold=%b rep=%b at cycle %0d",
               inst, cycle, e.press, e.rel, e.hold, e.rep, e.cyc);
      if (inst == 0) void'(q_a.pop_front());
      else           void'(q_b.pop_front());
      n--;
    end
    if (busy) begin
      checks++;
      if (n > 0 && e.cyc == cycle) begin
        if (inst == 0) void'(q_a.pop_front());
        else           void'(q_b.pop_front());
        if (p !== e.press || r !== e.rel || h !== e.hold || rp !== e.rep || lv !== e.level) begin
          errors++;
          $display("[TB] FAIL event inst=%0d cycle=%0d: got press=%b rel=%b hold=%b rep=%b level=%b, required press=%b rel=%b hold=%b rep=%b level=%b",
                   inst, cycle, p, r, h, rp, lv, e.press, e.rel, e.hold, e.rep, e.level);
        end
      end else begin
        errors++;
        $display("[TB] FAIL unexpected_pulse inst=%0d cycle=%0d: got press=%b rel=%b hold=%b rep=%b, required no pulse",
                 inst, cycle, p, r, h, rp);
      end
    end
  endtask

  // Monitor: samples both instances half a cycle after each active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      monitorInst(0, press_a, release_a, hold_a, repeat_a, level_a);
      monitorInst(1, press_b, release_b, hold_b, repeat_b, level_b);
    end
  end

  task automatic applyStimulus(input int inst, input logic [3:0] v, output int t);
    @(posedge clk);
    #1;
    if (inst == 0) in_a = v;
    else           in_b = v;
    t = cycle;
  endtask

  task automatic waitUntil(input int c);
    while (cycle < c) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int inst, input logic [3:0] exp_level);
    logic [3:0] act;
    act = (inst == 0) ? level_a : level_b;
    checks++;
    if (act !== exp_level) begin
      errors++;
      $display("[TB] FAIL %s inst=%0d cycle=%0d: level got %b, required %b", name, inst, cycle, act, exp_level);
    end
  endtask

  task automatic finishRun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  initial begin
    int         t, p, r;
    logic [3:0] bounce [5];

    rst_a = 1'b1; rst_b = 1'b1;
    in_a  = 4'hF; in_b  = 4'hF;
    @(posedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_level", 0, 4'hF);
    checkOutput("reset_level", 1, 4'hF);
    @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Idle with inputs released: level stays high, monitor flags any pulse.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("idle_level", 0, 4'hF);
      checkOutput("idle_level", 1, 4'hF);
    end

    // Clean press on ch0, then a quick release before hold can fire.
    applyStimulus(0, 4'b1110, t);
    p = t + 6;
    pushExp(0, p, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1110);
    waitUntil(p - 1);
    checkOutput("press_latency_before", 0, 4'b1111);
    waitUntil(p);
    checkOutput("press_latency_at", 0, 4'b1110);
    applyStimulus(0, 4'b1111, t);
    pushExp(0, t + 6, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1111);
    waitUntil(t + 12);

    // Bounce on ch1: three low, one high, then low; the short run must not count.
    bounce = '{4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1101};
    for (int i = 0; i < 5; i++) applyStimulus(0, bounce[i], t);
    p = t + 6;
    pushExp(0, p, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b1101);
    waitUntil(p - 1);
    checkOutput("bounce_level_before", 0, 4'b1111);
    waitUntil(p);
    checkOutput("bounce_level_at", 0, 4'b1101);
    applyStimulus(0, 4'b1111, t);
    pushExp(0, t + 6, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1111);
    waitUntil(t + 12);

    // Long press on ch2: hold at +20, repeats every 8 until release at +62.
    applyStimulus(0, 4'b1011, t);
    p = t + 6;
    pushExp(0, p,      4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1011);
    pushExp(0, p + 20, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1011);
    for (int k = 0; k < 5; k++)
      pushExp(0, p + 28 + 8 * k, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1011);
    waitUntil(p + 55);
    applyStimulus(0, 4'b1111, t);
    pushExp(0, t + 6, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b1111);
    waitUntil(t + 6);
    checkOutput("long_release_level", 0, 4'b1111);
    waitUntil(t + 20);

    // ch0 and ch3 together: both pulses in the same cycle.
    applyStimulus(0, 4'b0110, t);
    pushExp(0, t + 6, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0110);
    waitUntil(t + 6);
    checkOutput("dual_press_level", 0, 4'b0110);
    applyStimulus(0, 4'b1111, t);
    pushExp(0, t + 6, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b1111);
    waitUntil(t + 12);

    // Reset on the very edge a repeat is due; key stays down through it.
    applyStimulus(0, 4'b1011, t);
    p = t + 6;
    pushExp(0, p,      4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1011);
    pushExp(0, p + 20, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1011);
    pushExp(0, p + 28, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1011);
    waitUntil(p + 35);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    r = cycle;
    @(negedge clk);
    checkOutput("reset_mid_press_level", 0, 4'b1111);
    pushExp(0, r + 6, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1011);
    waitUntil(r + 5);
    checkOutput("repress_before", 0, 4'b1111);
    waitUntil(r + 6);
    checkOutput("repress_at", 0, 4'b1011);
    applyStimulus(0, 4'b1111, t);
    pushExp(0, t + 6, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b1111);
    waitUntil(t + 12);

    // Repeat disabled: one hold pulse and no repeats over the same long press.
    applyStimulus(1, 4'b1011, t);
    p = t + 6;
    pushExp(1, p,      4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1011);
    pushExp(1, p + 20, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1011);
    waitUntil(p + 55);
    checkOutput("norep_held_level", 1, 4'b1011);
    applyStimulus(1, 4'b1111, t);
    pushExp(1, t + 6, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b1111);
    waitUntil(t + 20);

    // Anything still queued was never observed.
    foreach (q_a[i]) begin
      checks++; errors++;
      $display("[TB] FAIL leftover_event inst=0: required event at cycle %0d never seen", q_a[i].cyc);
    end
    foreach (q_b[i]) begin
      checks++; errors++;
      $display("[TB] FAIL leftover_event inst=1: required event at cycle %0d never seen", q_b[i].cyc);
    end
    finishRun();
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: run exceeded time limit at cycle %0d, required completion", cycle);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
